// File: rtl/iter_mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute-stage MDU interface.
// Radix-2: one product/quotient bit per cycle (shift-add multiply, restoring divide).
// Operands are reduced to magnitudes on entry. A single two's-complement fix-up at
// the end restores the sign. W-form operations run for 32 iterations and
// sign-extend bit 31.
// Optional build macro MDU_EARLY_OUT_EN: trivial cases (multiply by zero,
// divide by zero, signed MIN / -1) finish in one cycle with identical results.
module iter_mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_e,
    input  logic [2:0]      i_op,
    input  logic            i_w32,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic            o_valid,
    output logic [XLEN-1:0] o_dest,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MASK32 = XLEN'({32{1'b1}});

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              w32_q;
    logic              a_neg_q;
    logic              res_neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   opb_q;

    logic              w32_eff;
    logic              is_div;
    logic              signed_a;
    logic              signed_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              b_zero;
    logic              res_neg;

    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_sel;
    logic [XLEN-1:0]   fix_res;

    logic              early_hit;
    logic [XLEN-1:0]   early_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign o_valid = i_e && (state == S_DONE);
    assign o_busy  = (state == S_BUSY) || (state == S_FIX);

    // Decode a new request: operand magnitudes, signs and divide-by-zero detection
    always_comb begin
        w32_eff  = i_w32 & (XLEN > 32);
        is_div   = i_op[2];
        signed_a = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                   (i_op == OP_DIV)  || (i_op == OP_REM);
        signed_b = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        a_neg    = signed_a & (w32_eff ? i_src1[31] : i_src1[XLEN-1]);
        b_neg    = signed_b & (w32_eff ? i_src2[31] : i_src2[XLEN-1]);
        a_mag    = (a_neg ? -i_src1 : i_src1) & (w32_eff ? MASK32 : '1);
        b_mag    = (b_neg ? -i_src2 : i_src2) & (w32_eff ? MASK32 : '1);
        b_zero   = (b_mag == '0);
        res_neg  = is_div ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);
    end

    // One radix-2 step: conditional add for multiply, trial subtract for divide
    always_comb begin
        mul_addend = lo_q[0] ? opb_q : '0;
        mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
        div_shift  = {hi_q, lo_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, opb_q};
    end

    // Final sign correction and result selection
    always_comb begin
        prod_full = w32_q ? (2*XLEN)'({hi_q[31:0], lo_q[XLEN-1:XLEN-32]}) : {hi_q, lo_q};
        prod_s    = res_neg_q ? -prod_full : prod_full;
        quo_s     = res_neg_q ? -lo_q : lo_q;
        rem_s     = a_neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       fix_sel = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_sel = w32_q ? XLEN'(prod_s[63:32])
                                                          : prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_sel = quo_s;
            default:                      fix_sel = rem_s;
        endcase
        fix_res = w32_q ? sext32(fix_sel[31:0]) : fix_sel;
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic a_is_min;
    logic b_is_m1;

    // Recognise operations whose result is known without iterating
    always_comb begin
        a_is_min  = w32_eff ? (i_src1[31:0] == 32'h8000_0000) : (i_src1 == MINV);
        b_is_m1   = w32_eff ? (&i_src2[31:0]) : (&i_src2);
        early_hit = 1'b0;
        early_res = '0;
        if (!is_div && ((a_mag == '0) || (b_mag == '0))) begin
            early_hit = 1'b1;
            early_res = '0;
        end else if (is_div && b_zero) begin
            early_hit = 1'b1;
            early_res = i_op[1] ? i_src1 : '1;
        end else if (is_div && signed_b && a_is_min && b_is_m1) begin
            early_hit = 1'b1;
            early_res = i_op[1] ? '0 : i_src1;
        end
        if (w32_eff) begin
            early_res = sext32(early_res[31:0]);
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_res = '0;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            state     <= S_IDLE;
            o_dest    <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            w32_q     <= 1'b0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_e) begin
                        op_q      <= i_op;
                        w32_q     <= w32_eff;
                        a_neg_q   <= a_neg;
                        res_neg_q <= res_neg;
                        cnt_q     <= w32_eff ? CW'(32) : CW'(XLEN);
                        hi_q      <= '0;
                        if (is_div) begin
                            lo_q  <= w32_eff ? (a_mag << (XLEN - 32)) : a_mag;
                            opb_q <= b_mag;
                        end else begin
                            lo_q  <= b_mag;
                            opb_q <= a_mag;
                        end
                        if (early_hit) begin
                            o_dest <= early_res;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            hi_q <= div_diff[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= div_shift[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    o_dest <= fix_res;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (i_e && !i_stall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul_div_unit.sv
// Directed testbench for iter_mul_div_unit (XLEN=32).
// Each vector checks result value, latency and the busy flag.
// It also exercises reset, flush abort, stall/hold in DONE and back-to-back issue.
// Expected latencies for trivial cases follow the MDU_EARLY_OUT_EN build macro.
module tb_iter_mul_div_unit;

    localparam int XLEN     = 32;
    localparam int FULL_LAT = 34;
`ifdef MDU_EARLY_OUT_EN
    localparam int TRIV_LAT = 1;
`else
    localparam int TRIV_LAT = 34;
`endif

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_flush;
    logic            i_stall;
    logic            i_e;
    logic [2:0]      i_op;
    logic            i_w32;
    logic [XLEN-1:0] i_src1;
    logic [XLEN-1:0] i_src2;
    logic            o_valid;
    logic [XLEN-1:0] o_dest;
    logic            o_busy;

    int tests_run;
    int tests_failed;

    iter_mul_div_unit #(.XLEN(XLEN)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_stall (i_stall),
        .i_e     (i_e),
        .i_op    (i_op),
        .i_w32   (i_w32),
        .i_src1  (i_src1),
        .i_src2  (i_src2),
        .o_valid (o_valid),
        .o_dest  (o_dest),
        .o_busy  (o_busy)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op   = op;
        i_src1 = a;
        i_src2 = b;
        i_w32  = 1'b0;
        i_e    = 1'b1;
    endtask

    task automatic waitResult(input string tag, input logic [31:0] exp, input int exp_lat);
        int cycles;
        int busy_miss;
        cycles    = 0;
        busy_miss = 0;
        while (!o_valid && cycles < 200) begin
            tick();
            cycles++;
            if (o_busy == o_valid) busy_miss++;
        end
        if (exp_lat != 0) checkOutput({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
        checkOutput({tag, "_busy"}, 64'(busy_miss), 64'd0);
        checkOutput(tag, 64'(o_dest), 64'(exp));
    endtask

    task automatic consumeResult();
        i_stall = 1'b0;
        tick();
        i_e = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        applyStimulus(op, a, b);
        waitResult(tag, exp, exp_lat);
        consumeResult();
    endtask

    initial begin
        int seen;
        int hold_bad;
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_e     = 1'b1;
        i_op    = OP_MUL;
        i_w32   = 1'b0;
        i_src1  = 32'd5;
        i_src2  = 32'd6;

        // Reset holds everything idle even with a request pending
        repeat (3) tick();
        checkOutput("reset_valid", 64'(o_valid), 64'd0);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        checkOutput("reset_dest", 64'(o_dest), 64'd0);
        i_e     = 1'b0;
        i_rst_n = 1'b1;
        tick();

        // Multiply family
        runOp("mul_7_m3",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
        runOp("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT);
        runOp("mulhu_ff_ff",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
        runOp("mulhsu_ff_ff",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT);
        runOp("mul_zero",      OP_MUL,    32'd123,       32'd0,         32'd0,         TRIV_LAT);

        // Divide family
        runOp("divu_100_7",    OP_DIVU,   32'd100,       32'd7,         32'd14,        FULL_LAT);
        runOp("remu_100_7",    OP_REMU,   32'd100,       32'd7,         32'd2,         FULL_LAT);
        runOp("div_min_m1",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, TRIV_LAT);
        runOp("rem_min_m1",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
        runOp("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, FULL_LAT);
        runOp("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, FULL_LAT);
        runOp("divu_big_16",   OP_DIVU,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, FULL_LAT);
        runOp("div_5_0",       OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, TRIV_LAT);
        runOp("rem_m5_0",      OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, TRIV_LAT);

        // Flush aborts an in-flight divide; a fresh request follows immediately
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_valid) seen++;
        end
        checkOutput("flush_busy_before", 64'(o_busy), 64'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        if (o_valid) seen++;
        checkOutput("flush_busy_after", 64'(o_busy), 64'd0);
        checkOutput("flush_no_valid", 64'(seen), 64'd0);
        runOp("flush_mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, FULL_LAT);

        // Result held in DONE while upstream stalls, then consumed
        applyStimulus(OP_MUL, 32'h1234, 32'h10);
        waitResult("stall_mul", 32'h0001_2340, FULL_LAT);
        i_stall  = 1'b1;
        i_e      = 1'b0;
        hold_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (o_valid || o_busy || (o_dest !== 32'h0001_2340)) hold_bad++;
        end
        checkOutput("stall_hold", 64'(hold_bad), 64'd0);
        i_e = 1'b1;
        #1;
        checkOutput("stall_revalid", 64'(o_valid), 64'd1);
        checkOutput("stall_dest", 64'(o_dest), 64'h0001_2340);
        tick();
        checkOutput("stall_keep", 64'(o_valid), 64'd1);
        consumeResult();
        checkOutput("consume_valid", 64'(o_valid), 64'd0);

        // Back-to-back issue right after consumption starts a full new operation
        runOp("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
